// File: rtl/state_pkg.sv
// rtl/state_pkg.sv - display pipeline state encodings and BMP geometry helper
package state_pkg;

  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} Vstate_t;
  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} Hstate_t;
  typedef enum logic [1:0] {IDLE, ARM, RUN, LAST} Fstate_t;

  // BMP rows are padded to a multiple of four bytes
  function automatic int bmp_stride(input int hres);
    return ((3 * hres + 3) / 4) * 4;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - D-stage shift register with synchronous active-low flush
module sync_delay #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         i_clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [D];

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[D-1];

endmodule

// File: rtl/bmp_fetch_ctrl.sv
// rtl/bmp_fetch_ctrl.sv - BMP pixel fetch scheduler and video re-timer
module bmp_fetch_ctrl
  import state_pkg::*;
#(
  parameter int HRES   = 4,
  parameter int VRES   = 4,
  parameter int AW     = 16,
  parameter int BASE   = 0,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_vsync,
  input  logic          i_hsync,
  input  logic          i_de,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [23:0]   i_rd_data,
  output logic          o_vsync,
  output logic          o_hsync,
  output logic          o_de,
  output logic [23:0]   o_pix,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_err
);

  localparam int            STRIDE_I = bmp_stride(HRES);
  localparam logic [AW-1:0] STRIDE   = AW'(STRIDE_I);
  localparam logic [AW-1:0] TOP      = AW'(BASE + (VRES - 1) * STRIDE_I);
  localparam logic [15:0]   HRES_W   = 16'(HRES);
  localparam logic [15:0]   VRES_W   = 16'(VRES);

  Fstate_t       state;
  logic          prev_vsync;
  logic          prev_de;
  logic [AW-1:0] row_base;
  logic [AW-1:0] col_off;
  logic [15:0]   x_cnt;
  logic [15:0]   y_cnt;
  logic          data_valid;

  logic active;
  logic issue;
  logic vs_rise;
  logic de_fall;

  assign active  = (state == RUN) || (state == LAST);
  assign issue   = active && i_de;
  assign vs_rise = i_vsync && !prev_vsync;
  assign de_fall = prev_de && !i_de;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev_vsync   <= 1'b0;
      prev_de      <= 1'b0;
      row_base     <= '0;
      col_off      <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      prev_vsync   <= i_vsync;
      prev_de      <= i_de;
      o_rd_en      <= issue;
      o_frame_done <= 1'b0;
      if (issue) begin
        o_rd_addr <= row_base + col_off;
        col_off   <= col_off + AW'(3);
        x_cnt     <= x_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= ARM;
            o_err <= 1'b0;
          end
        end
        ARM: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (vs_rise) begin
            state    <= RUN;
            row_base <= TOP;
            col_off  <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
          end
        end
        RUN, LAST: begin
          // Memory rows are stored bottom-up, so each displayed line steps back one stride
          if (de_fall) begin
            row_base <= row_base - STRIDE;
            col_off  <= '0;
            y_cnt    <= y_cnt + 16'd1;
            x_cnt    <= '0;
            if (x_cnt != HRES_W) o_err <= 1'b1;
          end
          if (vs_rise) begin
            o_frame_done <= 1'b1;
            if (y_cnt != VRES_W) o_err <= 1'b1;
            row_base <= TOP;
            col_off  <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            state    <= (state == LAST) ? IDLE : RUN;
          end
          if (i_stop && state == RUN) state <= LAST;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Marks the cycle on which i_rd_data carries a requested pixel
  sync_delay #(.W(1), .D(RD_LAT)) u_valid (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .din   (o_rd_en),
    .dout  (data_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!rst_n) o_pix <= '0;
    else        o_pix <= data_valid ? i_rd_data : 24'h0;
  end

  sync_delay #(.W(3), .D(RD_LAT + 2)) u_sync (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .din   ({i_vsync, i_hsync, issue}),
    .dout  ({o_vsync, o_hsync, o_de})
  );

endmodule

// File: doc/bmp_fetch_ctrl.md
# bmp_fetch_ctrl

Pixel-fetch scheduler between the display sync generator and the BMP pixel memory. It consumes the sync generator's vsync/hsync/de outputs and issues one read per active pixel, converting BMP bottom-up, 4-byte-padded row order into top-down raster addresses. It re-times the returned 24-bit pixels and the sync signals into an aligned video stream. It also provides start/stop sequencing at frame boundaries and geometry error detection.

## Interface
- HRES, 4: active pixels per line
- VRES, 4: active lines per frame
- AW, 16: read address width (bytes)
- BASE, 0: byte address of BMP pixel-array start
- RD_LAT, 1: memory read latency in cycles (≥1)

- i_clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_start  in  1  start pulse; ignored while o_busy
- i_stop  in  1  stop pulse; takes effect at next frame boundary
- i_vsync, i_hsync, i_de  in  1 each  from sync generator
- o_rd_en  out  1  memory read strobe
- o_rd_addr  out  AW  byte address of pixel B,G,R triple
- i_rd_data  in  24  pixel data, valid RD_LAT cycles after o_rd_en
- o_vsync, o_hsync, o_de  out  1 each  aligned sync/de
- o_pix  out  24  pixel, 0 when o_de low
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse per completed frame
- o_err  out  1  sticky geometry error

## Operation
- STRIDE = ((3*HRES+3)/4)*4; TOP = BASE + (VRES-1)*STRIDE; all address arithmetic modulo 2^AW.
- FSM Fstate_t: IDLE, ARM, RUN, LAST.
  - IDLE: i_start → ARM; clears o_err.
  - ARM: vsync rising edge (i_vsync & ~prev) → RUN; row_base←TOP, col_off←0, x←0, y←0.
  - RUN: each cycle with i_de: o_rd_en, o_rd_addr=row_base+col_off, col_off+=3, x+=1. On de falling edge: row_base-=STRIDE, col_off←0, y+=1, check x==HRES, x←0. i_stop seen → LAST (current frame continues).
  - RUN/LAST on vsync rising edge: check y==VRES, pulse o_frame_done; RUN reloads row_base←TOP, y←0 and stays; LAST → IDLE.
- Geometry check failure sets o_err; held until next accepted i_start.
- i_de while IDLE/ARM: no reads; o_de stays low.
- i_start and i_stop together in IDLE: start wins, stop is dropped.
- Stop latch: i_stop in ARM → IDLE immediately.

## Timing
- o_rd_en/o_rd_addr registered: i_de at cycle n → read at n+1.
- o_pix registered from i_rd_data at n+1+RD_LAT → visible n+2+RD_LAT.
- o_vsync/o_hsync/o_de = inputs delayed RD_LAT+2 cycles. o_de is additionally gated by "read issued" (delayed identically) so it is low for unfetched pixels.
- o_frame_done: registered, cycle after the vsync rising edge.
- Reset (anytime, incl. mid-frame): state IDLE. All outputs 0, delay lines flushed, counters 0. First read no earlier than the first vsync edge after i_start.
- Back-to-back de lines (hsync width 0) are handled; the falling edge is computed from a registered previous de.

## Structure
- state_pkg: add Fstate_t (logic[1:0] enum IDLE/ARM/RUN/LAST) beside existing Vstate_t/Hstate_t.
- Sub-module sync_delay #(W, D): D-stage shift register with synchronous active-low reset. Used for {vsync, hsync, de_gated} with W=3, D=RD_LAT+2.
- STRIDE and TOP are localparams in the block.

## Test plan
- HRES=3, VRES=2, BASE=0, RD_LAT=1, memory model returns addr as data. After start and vsync, line 0 reads 12,15,18; line 1 reads 0,3,6. STRIDE=12 padding is verified. o_pix matches o_de 3 cycles after i_de.
- HRES=4, VRES=4: two full frames. o_frame_done pulses once per vsync edge; o_err=0; o_busy stays 1.
- i_stop mid-frame 1: frame completes, o_frame_done pulses, state IDLE, no further o_rd_en during frame 2.
- Inject 3 de cycles in one line with HRES=4: o_err=1 and stays set. Next i_start clears it.
- rst_n low for 1 cycle mid-line: next cycle all outputs 0; o_rd_en stays 0 until start plus vsync edge.
- i_start in RUN is ignored. Addresses are continuous, and AW=8 with BASE=250 wraps modulo 256.
